// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges ALU results and buffered load results
// onto a single write port, and tracks registers still awaiting a load write.
module writeback_arbiter #(
  parameter int ADDR_SIZE    = 5,
  parameter int WORD_SIZE    = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [ADDR_SIZE-1:0] alu_addr,
  input  logic [WORD_SIZE-1:0] alu_data,
  output logic                 alu_stall,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 iss_en,
  input  logic [ADDR_SIZE-1:0] iss_addr,
  input  logic [ADDR_SIZE-1:0] rs_addr,
  input  logic [ADDR_SIZE-1:0] rt_addr,
  output logic                 rs_pend,
  output logic                 rt_pend,
  output logic                 rd_en,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int BLK_W    = $clog2(STARVE_LIMIT + 1);
  localparam int NUM_REGS = 1 << ADDR_SIZE;

  // Load-result FIFO storage; head is read combinationally so a pop can
  // be issued in the same cycle the arbiter decides.
  logic [ADDR_SIZE-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 alu_sel;
  logic                 fifo_write;
  logic [ADDR_SIZE-1:0] head_addr;
  logic [WORD_SIZE-1:0] head_data;

  logic                 rd_en_reg, rd_en_next;
  logic [ADDR_SIZE-1:0] rd_addr_reg, rd_addr_next;
  logic [WORD_SIZE-1:0] rd_data_reg, rd_data_next;
  logic                 from_fifo_reg, from_fifo_next;

  logic [BLK_W-1:0]     blocked_reg, blocked_next;
  logic                 alu_stall_reg, alu_stall_next;

  logic [NUM_REGS-1:0]  pending_reg, pending_next;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign mem_ready  = ~fifo_full;
  assign push       = mem_valid & mem_ready;
  assign head_addr  = fifo_addr_mem[rd_ptr_reg];
  assign head_data  = fifo_data_mem[rd_ptr_reg];

  // Source selection and next write-port contents.
  always_comb begin
    alu_sel        = alu_valid && (alu_addr != '0);
    pop            = !alu_sel && !fifo_empty;
    fifo_write     = pop && (head_addr != '0);
    rd_en_next     = alu_sel || fifo_write;
    from_fifo_next = fifo_write;
    rd_addr_next   = rd_addr_reg;
    rd_data_next   = rd_data_reg;
    if (alu_sel) begin
      rd_addr_next = alu_addr;
      rd_data_next = alu_data;
    end else if (fifo_write) begin
      rd_addr_next = head_addr;
      rd_data_next = head_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Starvation tracking: counts cycles the ALU keeps a waiting load off the
  // port; any pop resets both the count and the stall request.
  always_comb begin
    blocked_next   = blocked_reg;
    alu_stall_next = alu_stall_reg;
    if (pop) begin
      blocked_next   = '0;
      alu_stall_next = 1'b0;
    end else begin
      if (blocked_reg == BLK_W'(STARVE_LIMIT)) begin
        alu_stall_next = 1'b1;
      end
      if (alu_sel && !fifo_empty && (blocked_reg != BLK_W'(STARVE_LIMIT))) begin
        blocked_next = blocked_reg + BLK_W'(1);
      end
    end
  end

  // Scoreboard: a new issue to the same register overrides the completing load.
  assign pending_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pending
      logic set_bit;
      logic clr_bit;
      assign set_bit = iss_en && (iss_addr == ADDR_SIZE'(gi));
      assign clr_bit = rd_en_reg && from_fifo_reg && (rd_addr_reg == ADDR_SIZE'(gi));
      assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= mem_addr;
      fifo_data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      rd_data_reg   <= '0;
      from_fifo_reg <= 1'b0;
      blocked_reg   <= '0;
      alu_stall_reg <= 1'b0;
      pending_reg   <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      rd_data_reg   <= rd_data_next;
      from_fifo_reg <= from_fifo_next;
      blocked_reg   <= blocked_next;
      alu_stall_reg <= alu_stall_next;
      pending_reg   <= pending_next;
    end
  end

  assign rd_en     = rd_en_reg;
  assign rd_addr   = rd_addr_reg;
  assign rd_data   = rd_data_reg;
  assign alu_stall = alu_stall_reg;
  assign rs_pend   = pending_reg[rs_addr];
  assign rt_pend   = pending_reg[rt_addr];

endmodule
